// File: rtl/bus_addr_pkg.sv
// Address map and shared types for the CPU data-port controller.
// Slave windows, FSM encoding and error cause codes live here.
package bus_addr_pkg;

   localparam int N_SLV = 7;

   typedef enum logic [2:0] {
      SLV_RAM    = 3'd0,
      SLV_SW     = 3'd1,
      SLV_LED    = 3'd2,
      SLV_7SEG   = 3'd3,
      SLV_UART_A = 3'd4,
      SLV_UART_B = 3'd5,
      SLV_UART_C = 3'd6
   } slv_e;

   // Indexed by slv_e; lower index wins when windows overlap.
   localparam logic [31:0] BASE [N_SLV] = '{
      32'h0000_1000,
      32'h0000_2000,
      32'h0000_2004,
      32'h0000_2008,
      32'h0000_2010,
      32'h0000_2020,
      32'h0000_2030
   };

   localparam logic [31:0] MASK [N_SLV] = '{
      32'hFFFF_FC00,
      32'hFFFF_FFFC,
      32'hFFFF_FFFC,
      32'hFFFF_FFFC,
      32'hFFFF_FFF0,
      32'hFFFF_FFF0,
      32'hFFFF_FFF0
   };

   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t WAIT = 1'b1;

   localparam logic ERR_UNMAPPED = 1'b0;
   localparam logic ERR_TIMEOUT  = 1'b1;

endpackage

// File: rtl/bus_addr_match.sv
// Address decoder: compares the CPU address with every slave window
// and reports the hit vector plus the lowest-numbered matching slave.
module bus_addr_match
   import bus_addr_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int SEL_W  = 3
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [N_SLV-1:0]  hit_o,
   output logic [SEL_W-1:0]  sel_o,
   output logic              any_hit_o
);

   // Match all windows, then priority-encode from the top so index 0 wins.
   always_comb begin
      hit_o = '0;
      sel_o = '0;
      for (int k = 0; k < N_SLV; k++) begin
         hit_o[k] = (addr_i & ADDR_W'(MASK[k])) == ADDR_W'(BASE[k]);
      end
      for (int k = N_SLV - 1; k >= 0; k--) begin
         if (hit_o[k]) sel_o = SEL_W'(k);
      end
      any_hit_o = |hit_o;
   end

endmodule

// File: rtl/bus_addr_ctrl.sv
// Data-port bus controller: decodes, steers strobes, muxes read data,
// stalls the CPU on slow slaves, aborts hung accesses, logs errors.
module bus_addr_ctrl #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                N_SLV    = 7,
   parameter int                TIMEOUT  = 15,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [ADDR_W-1:0]              addr_i,
   input  logic                           we_i,
   input  logic                           re_i,
   input  logic [N_SLV-1:0][DATA_W-1:0]   rdata_slv_i,
   input  logic [N_SLV-1:0]               ready_slv_i,
   input  logic                           err_clr_i,
   output logic [N_SLV-1:0]               we_slv_o,
   output logic [N_SLV-1:0]               re_slv_o,
   output logic [DATA_W-1:0]              rdata_o,
   output logic                           stall_o,
   output logic                           err_o,
   output logic                           err_cause_o,
   output logic [ADDR_W-1:0]              err_addr_o,
   output logic [7:0]                     err_cnt_o
);

   import bus_addr_pkg::*;

   localparam int         SEL_W     = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   logic [N_SLV-1:0]  hit;
   logic [SEL_W-1:0]  sel;
   logic              any_hit;
   logic              mapped;
   logic              req;

   state_t            state_q, state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              wr_q, wr_d;

   logic              err_q, err_d;
   logic              cause_q, cause_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic              err_ev;
   logic              err_ev_cause;

   bus_addr_match #(
      .ADDR_W (ADDR_W),
      .SEL_W  (SEL_W)
   ) u_match (
      .addr_i    (addr_i),
      .hit_o     (hit),
      .sel_o     (sel),
      .any_hit_o (any_hit)
   );

   assign req    = we_i | re_i;
   assign mapped = any_hit & hit[sel];

   // Access FSM: strobes, read mux, stall and error-event detection.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      sel_d        = sel_q;
      wr_d         = wr_q;
      we_slv_o     = '0;
      re_slv_o     = '0;
      rdata_o      = '0;
      stall_o      = 1'b0;
      err_ev       = 1'b0;
      err_ev_cause = ERR_UNMAPPED;
      if (!rst_i) begin
         unique case (state_q)
            IDLE: begin
               if (req && mapped) begin
                  // A simultaneous read and write is treated as a write.
                  if (we_i) we_slv_o[sel] = 1'b1;
                  else      re_slv_o[sel] = 1'b1;
                  if (ready_slv_i[sel]) begin
                     if (!we_i) rdata_o = rdata_slv_i[sel];
                  end else begin
                     stall_o    = 1'b1;
                     sel_d      = sel;
                     wr_d       = we_i;
                     wait_cnt_d = '0;
                     state_d    = WAIT;
                  end
               end else if (req) begin
                  if (!we_i) rdata_o = ERR_DATA;
                  err_ev       = 1'b1;
                  err_ev_cause = ERR_UNMAPPED;
               end
            end
            WAIT: begin
               if (ready_slv_i[sel_q]) begin
                  if (wr_q) we_slv_o[sel_q] = 1'b1;
                  else      re_slv_o[sel_q] = 1'b1;
                  if (!wr_q) rdata_o = rdata_slv_i[sel_q];
                  state_d = IDLE;
               end else if (wait_cnt_q == LAST_WAIT) begin
                  rdata_o      = ERR_DATA;
                  err_ev       = 1'b1;
                  err_ev_cause = ERR_TIMEOUT;
                  state_d      = IDLE;
               end else begin
                  if (wr_q) we_slv_o[sel_q] = 1'b1;
                  else      re_slv_o[sel_q] = 1'b1;
                  stall_o    = 1'b1;
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
         endcase
      end
   end

   // Sticky error status: first error after a clear owns cause and address.
   always_comb begin
      err_d      = err_q;
      cause_d    = cause_q;
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;
      if (err_clr_i) begin
         err_d      = 1'b0;
         cause_d    = ERR_UNMAPPED;
         err_addr_d = '0;
      end
      if (err_ev && (!err_q || err_clr_i)) begin
         err_d      = 1'b1;
         cause_d    = err_ev_cause;
         err_addr_d = addr_i;
      end
      if (err_ev && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // FSM and latched access context.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         sel_q      <= '0;
         wr_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         sel_q      <= sel_d;
         wr_q       <= wr_d;
      end
   end

   // Error registers; the counter survives err_clr_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q      <= 1'b0;
         cause_q    <= ERR_UNMAPPED;
         err_addr_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         err_q      <= err_d;
         cause_q    <= cause_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign err_o       = err_q;
   assign err_cause_o = cause_q;
   assign err_addr_o  = err_addr_q;
   assign err_cnt_o   = err_cnt_q;

endmodule
